scan_channel_sequencer: RTL

- Sequencer that generates the 3-bit channel select driving the 3-to-8 one-hot decoder stage directly downstream.
- Steps through an 8-bit channel-enable mask, skips disabled channels and holds each enabled channel for a programmable dwell time.
- Supports single-pass and continuous scanning, with start/stop control and busy/done status for the controlling logic.

---
 rtl/scan_channel_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/scan_channel_sequencer.sv
// Channel scan sequencer: walks an enable mask and drives a 3-bit select for a
// downstream 3-to-8 decoder. Each enabled channel is held for dwell+1 cycles.
module scan_channel_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         ch_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               ch_adv,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;
    logic [DWELL_W-1:0] cnt;

    logic [2:0] first_en;
    logic [2:0] first_mask;
    logic [2:0] next_ch;
    logic       has_next;

    // Scanning from the top down lets the lowest qualifying index win.
    always_comb begin
        first_en   = '0;
        first_mask = '0;
        next_ch    = '0;
        has_next   = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ch_en[7 - i]) begin
                first_en = 3'(7 - i);
            end
            if (mask_q[7 - i]) begin
                first_mask = 3'(7 - i);
                if ((7 - i) > 32'(sel)) begin
                    next_ch  = 3'(7 - i);
                    has_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            ch_adv    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            mask_q    <= '0;
            dwell_q   <= '0;
            mode_q    <= 1'b0;
        end else begin
            ch_adv <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q  <= ch_en;
                        dwell_q <= dwell;
                        mode_q  <= mode;
                        if (ch_en == '0) begin
                            done <= 1'b1;
                        end else begin
                            sel       <= first_en;
                            sel_valid <= 1'b1;
                            ch_adv    <= 1'b1;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            state     <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == dwell_q) begin
                        cnt <= '0;
                        if (has_next) begin
                            sel    <= next_ch;
                            ch_adv <= 1'b1;
                        end else if (mode_q) begin
                            sel    <= first_mask;
                            ch_adv <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            sel_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
